axi_dma_rd_ctrl: RTL and testbench
==================================

Name: axi_dma_rd_ctrl

Overview:
Read-side DMA controller. It takes one transfer command (source address, byte length) and issues a sequence of INCR AXI read bursts to a memory-mapped AXI slave, such as the team's AXI slave memory model. Returned R beats are forwarded to a valid/ready stream for the write side of the DMA. It sequences the slave's read channel: one burst outstanding at a time, burst length chosen per burst, no burst crossing a 4 KB boundary.

Parameters:
AXI_ID_WD, 2, ARID/RID width
AXI_DATA_WD, 32, data width (32/64/128)
AXI_ADDR_WD, 32, address width
LEN_WD, 16, width of the byte-length field
MAX_BURST, 16, maximum beats per burst (1..256)
DMA_ID, 0, constant ARID driven on every burst

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  synchronous active-low reset
i_start  in  1  one-cycle command strobe
i_src_addr  in  AXI_ADDR_WD  start byte address, DATA_WD/8-aligned
i_len  in  LEN_WD  byte count, multiple of DATA_WD/8
o_busy  out  1  transfer in progress
o_done  out  1  one-cycle completion pulse
o_err  out  1  sticky: any RRESP != OKAY or RID mismatch in last transfer
M_AXI_ARADDR  out  AXI_ADDR_WD  burst start address
M_AXI_ARID  out  AXI_ID_WD  = DMA_ID
M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
M_AXI_ARSIZE  out  3  constant log2(DATA_WD/8)
M_AXI_ARLEN  out  8  beats-1
M_AXI_ARVALID  out  1  address valid
M_AXI_ARREADY  in  1  address ready
M_AXI_RDATA  in  AXI_DATA_WD  read data
M_AXI_RLAST  in  1  last beat
M_AXI_RID  in  AXI_ID_WD  read ID
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read valid
M_AXI_RREADY  out  1  read ready
o_tdata  out  AXI_DATA_WD  stream data (= M_AXI_RDATA)
o_tvalid  out  1  stream valid
o_tlast  out  1  last beat of the whole transfer
i_tready  in  1  stream ready

Behaviour:
- Reset: state IDLE. o_busy, o_done, o_err, ARVALID, RREADY, o_tvalid, o_tlast all 0. ARADDR and ARLEN 0.
- FSM IDLE -> ADDR -> DATA -> (ADDR | DONE) -> IDLE.
- IDLE: i_start=1 latches addr, clears o_err, sets beats_left = i_len >> log2(DATA_WD/8). If i_len==0, go to DONE directly with no AXI traffic. Otherwise go to ADDR. o_busy=1 from the cycle after start until DONE exits.
- i_start while busy: ignored, no state change.
- Burst length per burst: blen = min(beats_left, MAX_BURST, (4096 - addr[11:0]) >> log2(DATA_WD/8)). Compute it registered on ADDR entry. ARLEN=blen-1.
- ADDR: ARVALID=1. ARADDR/ARLEN stay stable until ARREADY. On handshake: ARVALID drops next cycle, go to DATA, addr += blen*DATA_WD/8.
- DATA: M_AXI_RREADY = i_tready (combinational). o_tvalid = M_AXI_RVALID (combinational). Zero added latency and no buffering. Each rfire: beats_left--, beat counter++.
- o_tlast = RVALID && beats_left==1.
- RLAST with rfire: if beats_left after the beat is 0, go to DONE, otherwise go to ADDR.
- RLAST on the wrong beat: count governs. Set o_err and continue.
- RRESP != 0 or RID != DMA_ID on any rfire sets o_err. The transfer is not aborted.
- DONE: o_done=1 for exactly one cycle, o_busy falls the same cycle, return to IDLE. o_err holds until the next start.
- Reset mid-transfer: immediate return to IDLE. Outputs follow reset values, no done pulse.
- Width rules: beats_left is LEN_WD bits. Address arithmetic wraps modulo 2^AXI_ADDR_WD. A misaligned i_src_addr is truncated to alignment (low bits forced 0).

Decomposition:
- Shared package axi_dma_pkg: AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, 4 KB boundary constant, FSM state encoding, clog2 helper for ARSIZE.
- Sub-module axi_burst_len: combinational (addr, beats_left) -> blen. Reused later by the write controller.

Test Plan:
- addr=0x0000, len=64 (32-bit, MAX_BURST=16), slave always ready -> one AR with ARLEN=15, 16 beats, o_tlast on beat 16, o_done one cycle after last rfire.
- addr=0x0FF0, len=32 -> two bursts: ARADDR=0x0FF0/ARLEN=3, then ARADDR=0x1000/ARLEN=3. No 4 KB crossing.
- len=0 -> no ARVALID ever, o_done pulses 2 cycles after i_start, o_busy high 1 cycle.
- len=256, i_tready toggling 1-0 every cycle -> RREADY mirrors i_tready, no beat lost or duplicated, data order preserved, 4 bursts of ARLEN=15.
- Slave returns RRESP=2'b10 on beat 3 of len=16 -> transfer completes, o_err=1 after done, cleared on next i_start.
- ARESETN asserted during DATA of len=128 -> next cycle idle, busy=0, ARVALID=0, no o_done. A new start then completes normally.

Source files
------------

// File: rtl/axi_dma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_dma_pkg                                                  |
// | Description : Shared constants, FSM state encoding and helper functions    |
// |               for the AXI DMA read/write controllers.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package axi_dma_pkg;

  localparam logic [1:0]  AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY     = 2'b00;
  localparam int unsigned AXI_4KB           = 4096;
  localparam int unsigned AXI_4KB_ADDR_BITS = 12;
  localparam int unsigned AXI_MAX_BLEN_WD   = 9;   // holds 1..256 beats

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

  // Ceiling log2, used for ARSIZE and byte<->beat conversions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_len.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_burst_len                                                |
// | Description : Combinational burst-length selector. Returns the number of   |
// |               beats for the next INCR burst: the minimum of the beats      |
// |               still owed, MAX_BURST, and the beats left before the next    |
// |               4 KB boundary.                                               |
// | Ports       : addr_lo_i    - low 12 bits of the burst start address        |
// |               beats_left_i - beats still to be transferred                 |
// |               blen_o       - beats in the next burst (1..MAX_BURST)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_burst_len
  import axi_dma_pkg::*;
#(
  parameter int unsigned LEN_WD    = 16,
  parameter int unsigned DATA_WD   = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic [AXI_4KB_ADDR_BITS-1:0] addr_lo_i,
  input  logic [LEN_WD-1:0]            beats_left_i,
  output logic [AXI_MAX_BLEN_WD-1:0]   blen_o
);

  localparam int unsigned c_SHIFT = clog2(DATA_WD / 8);
  // Common compare width: wide enough for the byte-length field and for 4096.
  localparam int unsigned c_CW    = (LEN_WD > 13) ? LEN_WD : 13;
  localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_BURST);
  localparam logic [c_CW-1:0] c_4KB = c_CW'(AXI_4KB);

  logic [c_CW-1:0] w_beats;
  logic [c_CW-1:0] w_room;
  logic [c_CW-1:0] w_cap;

  assign w_beats = c_CW'(beats_left_i);
  assign w_room  = (c_4KB - c_CW'(addr_lo_i)) >> c_SHIFT;
  assign w_cap   = (w_room < c_MAX) ? w_room : c_MAX;
  // w_cap never exceeds MAX_BURST (<=256), so the low 9 bits carry the value.
  assign blen_o  = (w_beats < w_cap) ? w_beats[AXI_MAX_BLEN_WD-1:0]
                                     : w_cap[AXI_MAX_BLEN_WD-1:0];

endmodule
`default_nettype wire

// File: rtl/axi_dma_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_dma_rd_ctrl                                              |
// | Description : Read-side DMA controller. Splits one (address, byte length)  |
// |               command into INCR AXI read bursts, one outstanding at a      |
// |               time, never crossing a 4 KB boundary, and forwards R beats   |
// |               unbuffered to a valid/ready stream.                          |
// | Ports       : M_AXI_ACLK/M_AXI_ARESETN - clock, sync active-low reset      |
// |               i_start/i_src_addr/i_len - command                           |
// |               o_busy/o_done/o_err      - status                            |
// |               M_AXI_AR*                - read address channel (master)     |
// |               M_AXI_R*                 - read data channel (master)        |
// |               o_tdata/o_tvalid/o_tlast/i_tready - output stream            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_dma_rd_ctrl
  import axi_dma_pkg::*;
#(
  parameter int unsigned AXI_ID_WD   = 2,
  parameter int unsigned AXI_DATA_WD = 32,
  parameter int unsigned AXI_ADDR_WD = 32,
  parameter int unsigned LEN_WD      = 16,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned DMA_ID      = 0
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESETN,
  input  logic                   i_start,
  input  logic [AXI_ADDR_WD-1:0] i_src_addr,
  input  logic [LEN_WD-1:0]      i_len,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [AXI_ADDR_WD-1:0] M_AXI_ARADDR,
  output logic [AXI_ID_WD-1:0]   M_AXI_ARID,
  output logic [1:0]             M_AXI_ARBURST,
  output logic [2:0]             M_AXI_ARSIZE,
  output logic [7:0]             M_AXI_ARLEN,
  output logic                   M_AXI_ARVALID,
  input  logic                   M_AXI_ARREADY,
  input  logic [AXI_DATA_WD-1:0] M_AXI_RDATA,
  input  logic                   M_AXI_RLAST,
  input  logic [AXI_ID_WD-1:0]   M_AXI_RID,
  input  logic [1:0]             M_AXI_RRESP,
  input  logic                   M_AXI_RVALID,
  output logic                   M_AXI_RREADY,
  output logic [AXI_DATA_WD-1:0] o_tdata,
  output logic                   o_tvalid,
  output logic                   o_tlast,
  input  logic                   i_tready
);

  localparam int unsigned           c_SHIFT = clog2(AXI_DATA_WD / 8);
  localparam logic [AXI_ID_WD-1:0]  c_ARID  = AXI_ID_WD'(DMA_ID);
  localparam logic [LEN_WD-1:0]     c_ONE   = LEN_WD'(1);

  dma_state_e             state_q, state_d;
  logic [AXI_ADDR_WD-1:0] addr_q, addr_d;
  logic [LEN_WD-1:0]      beats_left_q, beats_left_d;
  logic [7:0]             arlen_q, arlen_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [AXI_ADDR_WD-1:0]       w_src_aligned;
  logic [LEN_WD-1:0]            w_start_beats;
  logic [AXI_ADDR_WD-1:0]       w_addr_step;
  logic                         w_rfire;
  logic                         w_burst_last;
  logic [AXI_4KB_ADDR_BITS-1:0] w_bl_addr_lo;
  logic [LEN_WD-1:0]            w_bl_beats;
  logic [AXI_MAX_BLEN_WD-1:0]   w_blen;
  logic [7:0]                   w_bl_len_m1;

  // Misaligned start addresses are truncated down to a beat boundary.
  assign w_src_aligned = (i_src_addr >> c_SHIFT) << c_SHIFT;
  assign w_start_beats = i_len >> c_SHIFT;
  assign w_addr_step   = (AXI_ADDR_WD'(arlen_q) + AXI_ADDR_WD'(1)) << c_SHIFT;
  assign w_rfire       = (state_q == ST_DATA) && M_AXI_RVALID && i_tready;
  // The controller's own beat count decides where a burst ends, not RLAST.
  assign w_burst_last  = (beat_cnt_q == arlen_q);

  // The burst length is evaluated for the values that will be live on ADDR
  // entry: the fresh command from IDLE, or the post-beat count from DATA
  // (the address was already advanced at the AR handshake).
  assign w_bl_addr_lo = (state_q == ST_IDLE) ? w_src_aligned[AXI_4KB_ADDR_BITS-1:0]
                                             : addr_q[AXI_4KB_ADDR_BITS-1:0];
  assign w_bl_beats   = (state_q == ST_IDLE) ? w_start_beats : (beats_left_q - c_ONE);
  assign w_bl_len_m1  = 8'(w_blen - 9'd1);

  axi_burst_len #(
    .LEN_WD    (LEN_WD),
    .DATA_WD   (AXI_DATA_WD),
    .MAX_BURST (MAX_BURST)
  ) u_burst_len (
    .addr_lo_i    (w_bl_addr_lo),
    .beats_left_i (w_bl_beats),
    .blen_o       (w_blen)
  );

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      arlen_q      <= '0;
      beat_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      arlen_q      <= arlen_d;
      beat_cnt_q   <= beat_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    beats_left_d  = beats_left_q;
    arlen_d       = arlen_q;
    beat_cnt_d    = beat_cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    o_tvalid      = 1'b0;
    o_tlast       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d       = w_src_aligned;
          beats_left_d = w_start_beats;
          beat_cnt_d   = '0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
          if (w_start_beats == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ADDR;
            arlen_d = w_bl_len_m1;
          end
        end
      end

      ST_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_d    = ST_DATA;
          addr_d     = addr_q + w_addr_step;
          beat_cnt_d = '0;
        end
      end

      ST_DATA: begin
        M_AXI_RREADY = i_tready;
        o_tvalid     = M_AXI_RVALID;
        o_tlast      = M_AXI_RVALID && (beats_left_q == c_ONE);
        if (w_rfire) begin
          beats_left_d = beats_left_q - c_ONE;
          beat_cnt_d   = beat_cnt_q + 8'd1;
          if ((M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RID != c_ARID) ||
              (M_AXI_RLAST != w_burst_last)) begin
            err_d = 1'b1;
          end
          if (w_burst_last) begin
            if (beats_left_q == c_ONE) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ADDR;
              arlen_d = w_bl_len_m1;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_tdata       = M_AXI_RDATA;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARID    = c_ARID;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARSIZE  = 3'(c_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_axi_dma_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_dma_rd_ctrl                                           |
// | Description : Self-checking bench for axi_dma_rd_ctrl with a small AXI     |
// |               read slave whose data word equals the beat byte address.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axi_dma_rd_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_src_addr = '0;
  logic [15:0] i_len = '0;
  logic        o_busy, o_done, o_err;
  logic [31:0] araddr;
  logic [1:0]  arid, arburst;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic        arvalid, rready;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast, rvalid;
  logic [1:0]  rid, rresp;
  logic [31:0] o_tdata;
  logic        o_tvalid, o_tlast;
  logic        i_tready = 1'b1;

  always #5 clk = ~clk;

  axi_dma_rd_ctrl #(
    .AXI_ID_WD(2), .AXI_DATA_WD(32), .AXI_ADDR_WD(32),
    .LEN_WD(16), .MAX_BURST(16), .DMA_ID(0)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
    .i_start(i_start), .i_src_addr(i_src_addr), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .M_AXI_ARADDR(araddr), .M_AXI_ARID(arid), .M_AXI_ARBURST(arburst),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARLEN(arlen), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_RDATA(rdata), .M_AXI_RLAST(rlast),
    .M_AXI_RID(rid), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready), .o_tdata(o_tdata), .o_tvalid(o_tvalid),
    .o_tlast(o_tlast), .i_tready(i_tready)
  );

  // ---------------- AXI read slave model ----------------
  logic        ar_throttle = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        ar_rdy;
  logic        s_active;
  logic [31:0] s_addr;
  int          s_len, s_cnt;

  assign arready = ar_rdy;
  assign rid     = 2'b00;

  always @(posedge clk) begin
    if (!rstn) begin
      ar_rdy <= 1'b1; s_active <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0;
      rdata <= '0; rresp <= 2'b00; s_addr <= '0; s_len <= 0; s_cnt <= 0;
    end else begin
      ar_rdy <= ar_throttle ? ~ar_rdy : 1'b1;
      if (!s_active) begin
        if (arvalid && arready) begin
          s_active <= 1'b1; s_addr <= araddr; s_len <= int'(arlen); s_cnt <= 0;
          rvalid <= 1'b1; rdata <= araddr; rlast <= (arlen == 8'd0);
          rresp <= (araddr == err_addr) ? 2'b10 : 2'b00;
        end
      end else if (rvalid && rready) begin
        if (s_cnt == s_len) begin
          s_active <= 1'b0; rvalid <= 1'b0; rlast <= 1'b0; rresp <= 2'b00;
        end else begin
          rdata <= s_addr + 32'((s_cnt + 1) * 4);
          rlast <= ((s_cnt + 1) == s_len);
          rresp <= ((s_addr + 32'((s_cnt + 1) * 4)) == err_addr) ? 2'b10 : 2'b00;
          s_cnt <= s_cnt + 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] q_araddr[$];
  logic [7:0]  q_arlen[$];
  logic [31:0] q_data[$];
  logic        q_last[$];
  int done_cnt = 0, rr_viol = 0, attr_bad = 0, stab_bad = 0, done_busy = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;

  always @(negedge clk) begin
    if (rstn) begin
      if (arvalid && arready) begin
        q_araddr.push_back(araddr);
        q_arlen.push_back(arlen);
        if (arid != 2'd0 || arburst != 2'b01 || arsize != 3'd2) attr_bad++;
      end
      if (prev_wait && (araddr != prev_addr || arlen != prev_len || !arvalid)) stab_bad++;
      prev_wait = arvalid && !arready;
      prev_addr = araddr;
      prev_len  = arlen;
      if (o_tvalid && i_tready) begin
        q_data.push_back(o_tdata);
        q_last.push_back(o_tlast);
      end
      if ((o_tvalid && rready !== i_tready) || (rready && !i_tready)) rr_viol++;
      if (o_done) done_cnt++;
      if (o_done && o_busy) done_busy++;
    end else begin
      prev_wait = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    q_araddr.delete(); q_arlen.delete(); q_data.delete(); q_last.delete();
    done_cnt = 0; rr_viol = 0; attr_bad = 0; stab_bad = 0; done_busy = 0;
  endtask

  logic err_at_start;

  task automatic run_xfer(input logic [31:0] addr, input logic [15:0] len,
                          input bit toggle, input bit poke, input string tag);
    int cyc;
    clear_mon();
    @(posedge clk); #1;
    i_src_addr = addr; i_len = len; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    err_at_start = o_err;
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      i_tready = toggle ? ~i_tready : 1'b1;
      if (poke && cyc == 4) begin
        i_start = 1'b1; i_src_addr = 32'hDEAD_0000; i_len = 16'h0040;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_start = 1'b0;
    i_tready = 1'b1;
    chk({tag, "_no_timeout"}, 32'(cyc < 3000), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int n);
    int derr, lerr;
    derr = 0; lerr = 0;
    for (int k = 0; k < q_data.size(); k++) begin
      if (q_data[k] !== base + 32'(k * 4)) derr++;
      if (q_last[k] !== (k == n - 1)) lerr++;
    end
    chk({tag, "_beats"}, 32'(q_data.size()), 32'(n));
    chk({tag, "_data_order"}, 32'(derr), 32'd0);
    chk({tag, "_tlast"}, 32'(lerr), 32'd0);
    chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_busy"}, 32'(done_busy), 32'd0);
    chk({tag, "_ar_attr"}, 32'(attr_bad + stab_bad), 32'd0);
    chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
  endtask

  task automatic check_bursts(input string tag, input logic [31:0] a0, input int nb,
                              input logic [7:0] len_m1, input logic [31:0] step);
    int berr;
    berr = 0;
    for (int b = 0; b < q_araddr.size(); b++) begin
      if (q_araddr[b] !== a0 + 32'(b) * step) berr++;
      if (q_arlen[b] !== len_m1) berr++;
    end
    chk({tag, "_ar_count"}, 32'(q_araddr.size()), 32'(nb));
    chk({tag, "_ar_fields"}, 32'(berr), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_valids", {28'd0, arvalid, rready, o_tvalid, o_tlast}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // single 16-beat burst
    run_xfer(32'h0000_0000, 16'd64, 1'b0, 1'b0, "t1");
    check_bursts("t1", 32'h0, 1, 8'd15, 32'h40);
    check_stream("t1", 32'h0, 16);
    chk("t1_err", 32'(o_err), 32'd0);

    // 4 KB split, with a start pulse while busy that must be ignored
    run_xfer(32'h0000_0FF0, 16'd32, 1'b0, 1'b1, "t2");
    check_bursts("t2", 32'h0FF0, 2, 8'd3, 32'h10);
    check_stream("t2", 32'h0FF0, 8);

    // zero-length command: exact busy/done timing, no AR traffic
    clear_mon();
    @(posedge clk); #1;
    i_src_addr = 32'h0000_0700; i_len = 16'd0; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    @(negedge clk);
    chk("t3_busy_c1", {30'd0, o_busy, o_done}, 32'b10);
    @(negedge clk);
    chk("t3_busy_c2", {30'd0, o_busy, o_done}, 32'b01);
    @(negedge clk);
    chk("t3_busy_c3", {30'd0, o_busy, o_done}, 32'b00);
    chk("t3_no_ar", 32'(q_araddr.size()), 32'd0);

    // ready toggling on stream and AR channel, 4 bursts
    ar_throttle = 1'b1;
    run_xfer(32'h0000_3000, 16'd256, 1'b1, 1'b0, "t4");
    ar_throttle = 1'b0;
    check_bursts("t4", 32'h3000, 4, 8'd15, 32'h40);
    check_stream("t4", 32'h3000, 64);
    chk("t4_rready_mirror", 32'(rr_viol), 32'd0);

    // misaligned start truncated down
    run_xfer(32'h0000_0102, 16'd16, 1'b0, 1'b0, "t5");
    check_bursts("t5", 32'h0100, 1, 8'd3, 32'h10);
    check_stream("t5", 32'h0100, 4);

    // SLVERR on beat 3: completes, error sticky, cleared by next start
    err_addr = 32'h0000_5008;
    run_xfer(32'h0000_5000, 16'd16, 1'b0, 1'b0, "t6");
    err_addr = 32'hFFFF_FFFF;
    check_stream("t6", 32'h5000, 4);
    chk("t6_err_sticky", 32'(o_err), 32'd1);
    run_xfer(32'h0000_6000, 16'd8, 1'b0, 1'b0, "t6b");
    chk("t6b_err_cleared", 32'(err_at_start), 32'd0);
    chk("t6b_err_end", 32'(o_err), 32'd0);

    // reset in the middle of the data phase
    begin
      int cyc;
      clear_mon();
      @(posedge clk); #1;
      i_src_addr = 32'h0000_4000; i_len = 16'd128; i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
      cyc = 0;
      while (q_data.size() < 5 && cyc < 500) begin
        @(posedge clk); #1; cyc++;
      end
      chk("t7_reached_data", 32'(cyc < 500), 32'd1);
      rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      chk("t7_idle_after_rst", {29'd0, o_busy, arvalid, o_tvalid}, 32'd0);
      repeat (6) @(negedge clk);
      chk("t7_no_done", 32'(done_cnt), 32'd0);
    end
    run_xfer(32'h0000_0000, 16'd64, 1'b0, 1'b0, "t8");
    check_bursts("t8", 32'h0, 1, 8'd15, 32'h40);
    check_stream("t8", 32'h0, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
